pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: memory waits, fetch waits with redirect
// discard, branch flush, load-use bubble, and a saturating stall-cycle counter.
module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req,
    input  logic        im_ready,
    input  logic        dm_req,
    input  logic        dm_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        clr_cnt,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        stall_wb,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FETCH_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic [15:0] cnt_q, cnt_d;

    logic data_wait;
    logic fetch_wait;
    logic load_use;
    logic any_stall;

    assign data_wait  = dm_req & ~dm_ready;
    assign fetch_wait = im_req & ~im_ready;
    assign load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (data_wait) begin
                    {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = '1;
                    state_d = MEM_WAIT;
                end else if (fetch_wait) begin
                    stall_if  = 1'b1;
                    flush_id  = 1'b1;
                    flush_ex  = branch_taken;
                    discard_d = branch_taken;
                    state_d   = FETCH_WAIT;
                end else if (branch_taken) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dm_ready) begin
                    {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = '1;
                end else begin
                    state_d = RUN;
                end
            end
            FETCH_WAIT: begin
                if (data_wait) begin
                    {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = '1;
                end else if (!im_ready) begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    flush_ex = branch_taken;
                    if (branch_taken) begin
                        discard_d = 1'b1;
                    end
                end else begin
                    // A redirect pending or arriving now makes the returned word stale.
                    flush_id  = discard_q | branch_taken;
                    flush_ex  = branch_taken;
                    discard_d = 1'b0;
                    state_d   = RUN;
                end
            end
            default: begin
                state_d   = RUN;
                discard_d = 1'b0;
            end
        endcase

        if (rst) begin
            {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = '0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
        end
    end

    assign any_stall = stall_if | stall_id | stall_ex | stall_mem | stall_wb;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (any_stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            discard_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized
// stimulus against a behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        im_req, im_ready, dm_req, dm_ready;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, branch_taken, clr_cnt;
    logic        stall_if, stall_id, stall_ex, stall_mem, stall_wb;
    logic        flush_id, flush_ex;
    logic [15:0] stall_cnt;
    logic [6:0]  dut_o;

    int total;
    int bad;

    // Model state: which wait is outstanding, pending discard, counter value
    bit         m_mem, m_fetch, m_disc;
    int         m_cnt;
    bit         nx_mem, nx_fetch, nx_disc;
    logic [6:0] exp_o;

    pipe_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .im_req       (im_req),
        .im_ready     (im_ready),
        .dm_req       (dm_req),
        .dm_ready     (dm_ready),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .clr_cnt      (clr_cnt),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .stall_wb     (stall_wb),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .stall_cnt    (stall_cnt)
    );

    // {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex}
    assign dut_o = {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_eval();
        bit dwait, hazard;
        dwait    = dm_req && !dm_ready;
        hazard   = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        exp_o    = 7'b0;
        nx_mem   = m_mem;
        nx_fetch = m_fetch;
        nx_disc  = m_disc;
        if (rst) begin
            nx_mem = 0; nx_fetch = 0; nx_disc = 0;
        end else if (m_mem) begin
            if (!dm_ready) exp_o = 7'b1111100;
            else nx_mem = 0;
        end else if (dwait) begin
            exp_o = 7'b1111100;
            if (!m_fetch) nx_mem = 1;
        end else if (m_fetch) begin
            if (!im_ready) begin
                exp_o = {1'b1, 4'b0, 1'b1, branch_taken};
                if (branch_taken) nx_disc = 1;
            end else begin
                exp_o    = {5'b0, m_disc | branch_taken, branch_taken};
                nx_fetch = 0;
                nx_disc  = 0;
            end
        end else if (im_req && !im_ready) begin
            exp_o    = {1'b1, 4'b0, 1'b1, branch_taken};
            nx_fetch = 1;
            nx_disc  = branch_taken;
        end else if (branch_taken) begin
            exp_o = 7'b0000011;
        end else if (hazard) begin
            exp_o = 7'b1100001;
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            m_mem = 0; m_fetch = 0; m_disc = 0; m_cnt = 0;
        end else begin
            m_mem = nx_mem; m_fetch = nx_fetch; m_disc = nx_disc;
            if (clr_cnt) m_cnt = 0;
            else if (exp_o[6:2] != 5'b0) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end
        #1;
    endtask

    task automatic idle();
        im_req = 0; im_ready = 0; dm_req = 0; dm_ready = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
        branch_taken = 0; clr_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        im_req = 1; im_ready = 0; dm_req = 1; dm_ready = 0; branch_taken = 1;
        ex_mem_read = 1; ex_rd = 5'd3; id_rs1 = 5'd3;
        #2;
        total++;
        if (dut_o !== 7'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want %b", dut_o, 7'b0);
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        tick();
        rst = 0;
        idle();
        #2;
        total++;
        if (dut_o !== 7'b0) begin
            bad++; $display("FAIL reset_idle: got %b want %b", dut_o, 7'b0);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        logic [6:0] want;
        clr_cnt = 1; tick(); clr_cnt = 0;
        dm_req = 1; dm_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) dm_ready = 1;
            want = (i < 4) ? 7'b1111100 : 7'b0;
            #2;
            total++;
            if (dut_o !== want) begin
                bad++; $display("FAIL mem_wait c%0d: got %b want %b", i, dut_o, want);
            end
            tick();
        end
        total++;
        if (stall_cnt !== 16'd3) begin
            bad++; $display("FAIL mem_wait_cnt: got %0d want 3", stall_cnt);
        end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd2; id_rs2 = 5'd5;
        #2;
        total++;
        if (dut_o !== 7'b1100001) begin
            bad++; $display("FAIL load_use: got %b want %b", dut_o, 7'b1100001);
        end
        tick();
        ex_mem_read = 0; ex_rd = 5'd0;
        #2;
        total++;
        if (dut_o !== 7'b0) begin
            bad++; $display("FAIL load_use_bubble: got %b want %b", dut_o, 7'b0);
        end
        tick();
        ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #2;
        total++;
        if (dut_o !== 7'b0) begin
            bad++; $display("FAIL load_use_x0: got %b want %b", dut_o, 7'b0);
        end
        tick();
        idle();
    endtask

    task automatic test_fetch_discard();
        logic [6:0] want [7] = '{7'b1000010, 7'b1000011, 7'b1000010, 7'b0000010,
                                 7'b0000000, 7'b1000010, 7'b0000000};
        for (int i = 0; i < 7; i++) begin
            idle();
            im_req       = (i != 4);
            im_ready     = (i == 3 || i == 6);
            branch_taken = (i == 1);
            #2;
            total++;
            if (dut_o !== want[i]) begin
                bad++; $display("FAIL fetch_discard c%0d: got %b want %b", i + 1, dut_o, want[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_branch_over_loaduse();
        branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7;
        #2;
        total++;
        if (dut_o !== 7'b0000011) begin
            bad++; $display("FAIL branch_loaduse: got %b want %b", dut_o, 7'b0000011);
        end
        tick();
        idle();
    endtask

    task automatic test_saturate();
        clr_cnt = 1; dm_req = 1; dm_ready = 0;
        tick();
        clr_cnt = 0;
        for (int i = 0; i < 65534; i++) tick();
        total++;
        if (stall_cnt !== 16'hFFFE) begin
            bad++; $display("FAIL sat_preset: got %h want fffe", stall_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (stall_cnt !== 16'hFFFF) begin
                bad++; $display("FAIL sat_hold%0d: got %h want ffff", i, stall_cnt);
            end
        end
        clr_cnt = 1;
        #2;
        total++;
        if (dut_o !== 7'b1111100) begin
            bad++; $display("FAIL sat_clr_stall: got %b want %b", dut_o, 7'b1111100);
        end
        tick();
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL sat_clr: got %h want 0000", stall_cnt);
        end
        clr_cnt = 0; dm_ready = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        dm_req = 1; dm_ready = 0;
        tick();
        rst = 1;
        m_mem = 0; m_fetch = 0; m_disc = 0; m_cnt = 0;
        #2;
        total++;
        if (dut_o !== 7'b0 || stall_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_mid_wait: got %b cnt %0d want %b cnt 0", dut_o, stall_cnt, 7'b0);
        end
        tick();
        rst = 0;
        #2;
        total++;
        if (dut_o !== 7'b1111100) begin
            bad++; $display("FAIL rst_reenter: got %b want %b", dut_o, 7'b1111100);
        end
        tick();
        dm_req = 0;
        #2;
        total++;
        if (dut_o !== 7'b1111100) begin
            bad++; $display("FAIL rst_in_memwait: got %b want %b", dut_o, 7'b1111100);
        end
        dm_ready = 1;
        #1;
        total++;
        if (dut_o !== 7'b0) begin
            bad++; $display("FAIL rst_memwait_exit: got %b want %b", dut_o, 7'b0);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            im_req       = ($urandom_range(0, 1) == 1);
            im_ready     = ($urandom_range(0, 1) == 1);
            dm_req       = ($urandom_range(0, 3) == 0);
            dm_ready     = ($urandom_range(0, 1) == 1);
            branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_read  = ($urandom_range(0, 1) == 1);
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            clr_cnt      = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 63) == 0);
            if (rst) begin
                m_mem = 0; m_fetch = 0; m_disc = 0; m_cnt = 0;
            end
            #2;
            model_eval();
            total++;
            if (dut_o !== exp_o) begin
                bad++; $display("FAIL rand_out i=%0d: got %b want %b", i, dut_o, exp_o);
            end
            total++;
            if (stall_cnt !== 16'(m_cnt)) begin
                bad++; $display("FAIL rand_cnt i=%0d: got %0d want %0d", i, stall_cnt, m_cnt);
            end
            tick();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        total = 0; bad = 0;
        m_mem = 0; m_fetch = 0; m_disc = 0; m_cnt = 0;
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_mem_wait();
        test_load_use();
        test_fetch_discard();
        test_branch_over_loaduse();
        test_reset_mid_wait();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
